alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
Upstream neighbour of the 64-bit ALU: holds the 32 x 64-bit architectural register file and the ID/EX pipeline register that drives the ALU's A, B and control inputs.
- Reads two source registers and selects register or immediate for the B operand.
- Registers the operands and control with stall/flush support and accepts one write-back per cycle.
- Write-back data is bypassed into same-cycle reads.

Parameters:
WIDTH, 64, data width of registers and operands
NREG, 32, number of architectural registers (index width 5)
ZR_INDEX, 31, index of the hard-wired zero register (XZR)

Ports:
CLK  input  1  clock; all state changes on rising edge
RST_N  input  1  synchronous active-low reset
RN  input  5  source register index for operand A
RM  input  5  source register index for operand B / store data
IMM  input  WIDTH  sign-extended immediate from decode
ALUSRC  input  1  1: B takes IMM; 0: B takes register RM
ALU_CTL  input  4  ALU operation code, passed through to C
ID_VALID  input  1  decode stage presents a valid instruction
STALL  input  1  hold the ID/EX register contents
FLUSH  input  1  insert a bubble into the ID/EX register
WB_EN  input  1  write-back enable
WB_ADDR  input  5  write-back register index
WB_DATA  input  WIDTH  write-back data
A  output  WIDTH  registered operand A to ALU
B  output  WIDTH  registered operand B to ALU
C  output  4  registered ALU control
STORE_DATA  output  WIDTH  registered RM value (for store instructions)
EX_VALID  output  1  registered valid flag for the execute stage

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - All NREG registers are cleared to 0.
  - A, B, STORE_DATA are cleared to 0; C to 4'b0000; EX_VALID to 0.
  - Reset wins over WB_EN, STALL and FLUSH.
  - Reset asserted mid-stall or mid-write discards the write; the next cycle after release is clean.
- Register file:
  - Write: on a rising edge with RST_N=1 and WB_EN=1, reg[WB_ADDR] <= WB_DATA, unless WB_ADDR==ZR_INDEX, in which case the write is ignored.
  - Writes occur regardless of STALL and FLUSH.
- Read (combinational):
  - rn_val = 0 if RN==ZR_INDEX.
  - Else rn_val = WB_DATA if WB_EN && WB_ADDR==RN (write-first bypass).
  - Else rn_val = reg[RN].
  - rm_val is formed the same way from RM.
- Operand select: b_next = ALUSRC ? IMM : rm_val.
- ID/EX register, priority at each rising edge: reset > FLUSH > STALL > load.
  - FLUSH: EX_VALID<=0, A<=0, B<=0, STORE_DATA<=0, C<=4'b0000.
  - STALL (no FLUSH): all outputs hold their values.
  - Load: A<=rn_val, B<=b_next, STORE_DATA<=rm_val, C<=ALU_CTL, EX_VALID<=ID_VALID.
  - When ID_VALID=0 on a load, data fields are still loaded and EX_VALID=0.
- Latency: inputs sampled at edge N appear on the outputs after edge N (one cycle).
- A write-back during STALL does not update held outputs. Decode re-presents the instruction after the stall and reads the fresh value.
- Width rules: no arithmetic is performed; all fields are passed through at full WIDTH; IMM is already extended by decode.
- ALU_CTL values are passed through unmodified, including codes the ALU does not define.

Test Plan:
1. Reset then write: RST_N=0 for 2 cycles, then WB_EN=1, WB_ADDR=5, WB_DATA=64'h0000_0000_0000_00AA, then RN=5, RM=0, ALUSRC=0, ID_VALID=1 -> the cycle after load, A=64'hAA, B=0, EX_VALID=1; all outputs were 0 during reset.
2. Zero register: write 64'hFFFF to reg 31, then RN=31, RM=31 -> A=0, B=0, STORE_DATA=0.
3. Bypass: same cycle WB_EN=1, WB_ADDR=3, WB_DATA=64'h1234, RN=3, RM=3, ALUSRC=1, IMM=64'h10, ALU_CTL=4'b0010 -> next cycle A=64'h1234, B=64'h10, STORE_DATA=64'h1234, C=4'b0010.
4. Stall/flush priority: load A=64'h7, then STALL=1 for 3 cycles with new RN data -> A stays 64'h7. Then STALL=1 and FLUSH=1 -> EX_VALID=0, A=B=0, C=0.
5. Write during stall: stall with A=64'h7 from reg 2, WB writes reg 2=64'h9 -> A stays 64'h7. Release stall with RN=2 -> A=64'h9.
6. Reset mid-operation: WB_EN=1, WB_ADDR=4, WB_DATA=64'h55 in the same cycle as RST_N=0 -> reg 4 reads 0 after release; EX_VALID=0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - register file plus ID/EX operand register feeding the 64-bit ALU
module alu_operand_stage #(
  parameter int WIDTH    = 64,
  parameter int NREG     = 32,
  parameter int ZR_INDEX = 31
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       RN,
  input  logic [4:0]       RM,
  input  logic [WIDTH-1:0] IMM,
  input  logic             ALUSRC,
  input  logic [3:0]       ALU_CTL,
  input  logic             ID_VALID,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic             WB_EN,
  input  logic [4:0]       WB_ADDR,
  input  logic [WIDTH-1:0] WB_DATA,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [3:0]       C,
  output logic [WIDTH-1:0] STORE_DATA,
  output logic             EX_VALID
);

  localparam logic [4:0] ZR = 5'(ZR_INDEX);

  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] rn_val;
  logic [WIDTH-1:0] rm_val;
  logic [WIDTH-1:0] b_next;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (WB_EN && WB_ADDR != ZR) begin
      regs[WB_ADDR] <= WB_DATA;
    end
  end

  // Write-first bypass: a same-cycle write-back is visible to decode reads.
  always_comb begin
    rn_val = regs[RN];
    if (RN == ZR)
      rn_val = '0;
    else if (WB_EN && WB_ADDR == RN)
      rn_val = WB_DATA;
  end

  always_comb begin
    rm_val = regs[RM];
    if (RM == ZR)
      rm_val = '0;
    else if (WB_EN && WB_ADDR == RM)
      rm_val = WB_DATA;
  end

  assign b_next = ALUSRC ? IMM : rm_val;

  always_ff @(posedge CLK) begin
    if (!RST_N || FLUSH) begin
      A          <= '0;
      B          <= '0;
      C          <= 4'b0000;
      STORE_DATA <= '0;
      EX_VALID   <= 1'b0;
    end else if (!STALL) begin
      A          <= rn_val;
      B          <= b_next;
      C          <= ALU_CTL;
      STORE_DATA <= rm_val;
      EX_VALID   <= ID_VALID;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - self-checking bench for alu_operand_stage
module tb_alu_operand_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [4:0]  RN, RM, WB_ADDR;
  logic [63:0] IMM, WB_DATA;
  logic        ALUSRC, ID_VALID, STALL, FLUSH, WB_EN;
  logic [3:0]  ALU_CTL;
  logic [63:0] A, B, STORE_DATA;
  logic [3:0]  C;
  logic        EX_VALID;

  alu_operand_stage #(.WIDTH(64), .NREG(32), .ZR_INDEX(31)) dut (
    .CLK(CLK), .RST_N(RST_N), .RN(RN), .RM(RM), .IMM(IMM), .ALUSRC(ALUSRC),
    .ALU_CTL(ALU_CTL), .ID_VALID(ID_VALID), .STALL(STALL), .FLUSH(FLUSH),
    .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .A(A), .B(B), .C(C), .STORE_DATA(STORE_DATA), .EX_VALID(EX_VALID)
  );

  always #5 CLK = ~CLK;

  logic [63:0] mreg [32];
  logic [63:0] ea, eb, es;
  logic [3:0]  ec;
  logic        ev;
  int          nvec = 0;
  int          nmis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
    if (WB_EN && WB_ADDR == idx) return WB_DATA;
    return mreg[idx];
  endfunction

  task automatic idle();
    RN = 0; RM = 0; IMM = 0; ALUSRC = 0; ALU_CTL = 0; ID_VALID = 0;
    STALL = 0; FLUSH = 0; WB_EN = 0; WB_ADDR = 0; WB_DATA = 0;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [63:0] data);
    WB_EN = 1; WB_ADDR = addr; WB_DATA = data;
  endtask

  // Predict the edge from the current inputs, clock it, then compare every output.
  task automatic cycle(input string tag);
    logic [63:0] ra, rb;
    ra = model_read(RN);
    rb = model_read(RM);
    if (!RST_N) begin
      ea = 0; eb = 0; es = 0; ec = 0; ev = 0;
      for (int i = 0; i < 32; i++) mreg[i] = 64'd0;
    end else begin
      if (FLUSH) begin
        ea = 0; eb = 0; es = 0; ec = 0; ev = 0;
      end else if (!STALL) begin
        ea = ra; eb = ALUSRC ? IMM : rb; es = rb; ec = ALU_CTL; ev = ID_VALID;
      end
      if (WB_EN && WB_ADDR != 5'd31) mreg[WB_ADDR] = WB_DATA;
    end
    @(posedge CLK);
    #1;
    check({tag, "_a"}, A, ea);
    check({tag, "_b"}, B, eb);
    check({tag, "_c"}, {60'd0, C}, {60'd0, ec});
    check({tag, "_sd"}, STORE_DATA, es);
    check({tag, "_v"}, {63'd0, EX_VALID}, {63'd0, ev});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mreg[i] = 64'd0;
    ea = 0; eb = 0; es = 0; ec = 0; ev = 0;
    idle();
    RST_N = 0;
    wb(5'd7, 64'hDEAD);
    STALL = 1;
    cycle("rst0");
    cycle("rst1");
    check("rst_a_zero", A, 64'd0);
    check("rst_v_zero", {63'd0, EX_VALID}, 64'd0);

    // Reset then write, then read back through the pipeline register
    RST_N = 1; idle();
    wb(5'd5, 64'hAA);
    cycle("t1_wr");
    idle(); RN = 5; RM = 0; ID_VALID = 1;
    cycle("t1_ld");
    check("t1_a_aa", A, 64'hAA);
    check("t1_b_0", B, 64'd0);
    check("t1_valid", {63'd0, EX_VALID}, 64'd1);

    // Zero register ignores writes and always reads zero
    idle(); wb(5'd31, 64'hFFFF);
    cycle("t2_wr");
    idle(); RN = 31; RM = 31; ID_VALID = 1;
    cycle("t2_ld");
    check("t2_a_0", A, 64'd0);
    check("t2_sd_0", STORE_DATA, 64'd0);

    // Same-cycle write-back bypass
    idle(); wb(5'd3, 64'h1234);
    RN = 3; RM = 3; ALUSRC = 1; IMM = 64'h10; ALU_CTL = 4'b0010; ID_VALID = 1;
    cycle("t3");
    check("t3_a", A, 64'h1234);
    check("t3_b", B, 64'h10);
    check("t3_sd", STORE_DATA, 64'h1234);
    check("t3_c", {60'd0, C}, 64'h2);

    // Stall holds, flush beats stall
    idle(); wb(5'd2, 64'h7);
    cycle("t4_wr");
    idle(); RN = 2; ID_VALID = 1; ALU_CTL = 4'hF;
    cycle("t4_ld");
    check("t4_a7", A, 64'h7);
    for (int k = 0; k < 3; k++) begin
      idle(); STALL = 1; RN = 5; RM = 3; ID_VALID = 1; wb(5'd6, 64'h66 + 64'(k));
      cycle("t4_stall");
      check("t4_hold", A, 64'h7);
    end
    idle(); STALL = 1; FLUSH = 1; RN = 5; ID_VALID = 1;
    cycle("t4_flush");
    check("t4_flush_v", {63'd0, EX_VALID}, 64'd0);
    check("t4_flush_c", {60'd0, C}, 64'd0);

    // Write-back during stall is not seen until the instruction is re-presented
    idle(); RN = 2; ID_VALID = 1;
    cycle("t5_ld");
    idle(); STALL = 1; RN = 2; ID_VALID = 1; wb(5'd2, 64'h9);
    cycle("t5_stall");
    check("t5_hold7", A, 64'h7);
    idle(); RN = 2; ID_VALID = 1;
    cycle("t5_rel");
    check("t5_a9", A, 64'h9);

    // Reset discards a simultaneous write
    idle(); wb(5'd4, 64'h44);
    cycle("t6_pre");
    idle(); RST_N = 0; wb(5'd4, 64'h55); STALL = 1;
    cycle("t6_rst");
    idle(); RST_N = 1; RN = 4; RM = 4;
    cycle("t6_rd");
    check("t6_a0", A, 64'd0);
    check("t6_v0", {63'd0, EX_VALID}, 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      RST_N    = ($urandom_range(0, 59) != 0);
      RN       = 5'($urandom);
      RM       = 5'($urandom);
      IMM      = {$urandom, $urandom};
      ALUSRC   = 1'($urandom);
      ALU_CTL  = 4'($urandom);
      ID_VALID = 1'($urandom);
      STALL    = ($urandom_range(0, 3) == 0);
      FLUSH    = ($urandom_range(0, 7) == 0);
      WB_EN    = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       WB_ADDR = RN;
        1:       WB_ADDR = RM;
        default: WB_ADDR = 5'($urandom);
      endcase
      WB_DATA  = {$urandom, $urandom};
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
